z80fi_insn_capture: RTL and testbench
=====================================

Z80FI_INSN_CAPTURE -- requirements
Module: z80fi_insn_capture

Interface
REQ-001 SHALL have parameter TCYC_W, default 4, width of each per-M-cycle T-state count.
REQ-002 SHALL have port clk  input  1  sole clock; one clk edge = one T-state.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port insn_start  input  1  pulse at T1 of first M1 of each instruction; implies mcycle_start.
REQ-005 SHALL have port mcycle_start  input  1  pulse at T1 of every M-cycle.
REQ-006 SHALL have port mcycle_type  input  3  `CYCLE_*` code of the M-cycle starting this clk.
REQ-007 SHALL have port fetch_valid, fetch_byte  input  1, 8  instruction byte (opcode, prefix, displacement or immediate) accepted.
REQ-008 SHALL have port mem_rd_valid, mem_raddr, mem_rdata  input  1, 16, 8  non-instruction memory read.
REQ-009 SHALL have port cpu_ip, cpu_f, cpu_ix, cpu_iy  input  16, 8, 16, 16  live architectural registers.
REQ-010 SHALL have outputs z80fi_valid 1, z80fi_insn 32, z80fi_insn_len 3, z80fi_bus_raddr 16, z80fi_bus_rdata 8.
REQ-011 SHALL have outputs z80fi_reg_ip_in 16, z80fi_reg_f_in 8, z80fi_reg_ix_in 16, z80fi_reg_iy_in 16, z80fi_reg_ip_out 16, z80fi_reg_f_out 8.
REQ-012 SHALL have outputs z80fi_mcycle_type1..6 (3 each), z80fi_tcycles1..5 (TCYC_W each) and z80fi_overflow 1.

Function
REQ-013 SHALL implement states IDLE (no instruction open) and ACTIVE (accumulating).
REQ-014 IDLE + insn_start SHALL latch cpu_ip/f/ix/iy into the _in shadows, clear accumulators, enter ACTIVE and not assert z80fi_valid.
REQ-015 ACTIVE + insn_start SHALL retire the open instruction: on the next clk z80fi_valid=1 for exactly one cycle. _out fields SHALL be the cpu_ip/cpu_f values sampled on the insn_start clk. A new accumulation SHALL start on that same clk.
REQ-016 All z80fi_* outputs SHALL be registered and SHALL hold the last retired instruction until the next retire.
REQ-017 Instruction bytes SHALL pack in fetch order: byte0 -> insn[7:0], byte1 -> [15:8], byte2 -> [23:16], byte3 -> [31:24]. Unfetched bytes SHALL be 0.
REQ-018 insn_len SHALL equal bytes fetched, max 4. A 5th byte SHALL be discarded and SHALL set overflow for that instruction.
REQ-019 M-cycle index SHALL start at 1 on insn_start and increment on each mcycle_start; mcycle_typeN SHALL record mcycle_type at the start of the Nth M-cycle.
REQ-020 T-state counter SHALL count clks from an M-cycle's start up to the next mcycle_start/insn_start, then commit into tcyclesN. It SHALL saturate at 2^TCYC_W-1.
REQ-021 Unused slots SHALL be `CYCLE_NONE` / 0. The 6th M-cycle's T-count SHALL be discarded. A 7th mcycle_start SHALL set overflow.
REQ-022 Only the first mem_rd_valid per instruction SHALL capture bus_raddr/bus_rdata. Later reads SHALL be ignored. With no read, both SHALL be 0.
REQ-023 fetch_valid or mem_rd_valid coincident with insn_start SHALL belong to the new instruction.
REQ-024 mcycle_start, fetch_valid and mem_rd_valid SHALL be ignored in IDLE.
REQ-025 z80fi_overflow SHALL be reported alongside its instruction; valid still asserts.

Reset
REQ-026 reset SHALL force IDLE, z80fi_valid=0, all z80fi_* data outputs to 0, mcycle types to `CYCLE_NONE` and overflow to 0.
REQ-027 reset mid-instruction SHALL discard the open instruction; no valid SHALL be produced for it.
REQ-028 reset SHALL take priority over a coincident insn_start.

Verification
REQ-029 Two NOPs (byte 00; M1, 4 T each) after reset -> one valid after 2nd insn_start: insn=0, len=1, type1=M1, tcycles1=4, type2=NONE, ip_out=ip_in+1.
REQ-030 DD CB 05 7E with M-cycles M1/4, M1/4, MEM/3, MEM/5, MEM/4, IX=1000h, read 1005h->80h -> insn=7E05CBDDh, len=4, raddr=1005h, rdata=80h, tcycles=4,4,3,5,4, ip_out=ip_in+4.
REQ-031 Five fetch bytes, or seven M-cycles, in one instruction -> overflow=1, len=4, first four bytes kept, valid still pulses once.
REQ-032 reset asserted mid-instruction, then two instructions -> no valid before the 2nd post-reset insn_start; that valid reports only the first post-reset instruction.
REQ-033 Back-to-back insn_start with fetch_valid on the same clk -> valid pulses each retire; the coincident byte appears as byte0 of the following instruction.
REQ-034 M-cycle 20 T-states long, TCYC_W=4 -> tcyclesN=15.

Source files
------------

// File: rtl/z80fi_insn_capture.sv
// Collects per-instruction trace (bytes, M-cycle types/T-counts, first data read, regs) and
// publishes it as a registered record for one clk after the next insn_start; never stalls the CPU.
module z80fi_insn_capture #(
    parameter int TCYC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              insn_start,
    input  logic              mcycle_start,
    input  logic [2:0]        mcycle_type,
    input  logic              fetch_valid,
    input  logic [7:0]        fetch_byte,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_raddr,
    input  logic [7:0]        mem_rdata,
    input  logic [15:0]       cpu_ip,
    input  logic [7:0]        cpu_f,
    input  logic [15:0]       cpu_ix,
    input  logic [15:0]       cpu_iy,
    output logic              z80fi_valid,
    output logic [31:0]       z80fi_insn,
    output logic [2:0]        z80fi_insn_len,
    output logic [15:0]       z80fi_bus_raddr,
    output logic [7:0]        z80fi_bus_rdata,
    output logic [15:0]       z80fi_reg_ip_in,
    output logic [7:0]        z80fi_reg_f_in,
    output logic [15:0]       z80fi_reg_ix_in,
    output logic [15:0]       z80fi_reg_iy_in,
    output logic [15:0]       z80fi_reg_ip_out,
    output logic [7:0]        z80fi_reg_f_out,
    output logic [2:0]        z80fi_mcycle_type1,
    output logic [2:0]        z80fi_mcycle_type2,
    output logic [2:0]        z80fi_mcycle_type3,
    output logic [2:0]        z80fi_mcycle_type4,
    output logic [2:0]        z80fi_mcycle_type5,
    output logic [2:0]        z80fi_mcycle_type6,
    output logic [TCYC_W-1:0] z80fi_tcycles1,
    output logic [TCYC_W-1:0] z80fi_tcycles2,
    output logic [TCYC_W-1:0] z80fi_tcycles3,
    output logic [TCYC_W-1:0] z80fi_tcycles4,
    output logic [TCYC_W-1:0] z80fi_tcycles5,
    output logic              z80fi_overflow
);

    localparam logic [2:0]        CYCLE_NONE = 3'd0;
    localparam logic [TCYC_W-1:0] TCYC_MAX   = '1;
    localparam logic [TCYC_W-1:0] TCYC_ONE   = TCYC_W'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic retire, open_new, track;

    logic [31:0]       acc_insn;
    logic [2:0]        acc_len;
    logic [2:0]        acc_type [6];
    logic [TCYC_W-1:0] acc_tcyc [5];
    logic [TCYC_W-1:0] fin_tcyc [5];
    logic [2:0]        mc_idx;
    logic [TCYC_W-1:0] tcnt;
    logic [15:0]       acc_raddr;
    logic [7:0]        acc_rdata;
    logic              rd_seen;
    logic              acc_ovf;
    logic [15:0]       sh_ip, sh_ix, sh_iy;
    logic [7:0]        sh_f;
    logic [2:0]        out_type [6];
    logic [TCYC_W-1:0] out_tcyc [5];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        retire   = 1'b0;
        open_new = 1'b0;
        track    = 1'b0;
        case (state)
            IDLE: begin
                if (insn_start) begin
                    open_new = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                track    = !insn_start;
                retire   = insn_start;
                open_new = insn_start;
            end
            default: state_nx = IDLE;
        endcase
    end

    // T-counts as they would stand if the running M-cycle ended this clk
    always_comb begin
        for (int i = 0; i < 5; i++)
            fin_tcyc[i] = (mc_idx == 3'(i + 1)) ? tcnt : acc_tcyc[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z80fi_valid      <= 1'b0;
            z80fi_insn       <= '0;
            z80fi_insn_len   <= '0;
            z80fi_bus_raddr  <= '0;
            z80fi_bus_rdata  <= '0;
            z80fi_reg_ip_in  <= '0;
            z80fi_reg_f_in   <= '0;
            z80fi_reg_ix_in  <= '0;
            z80fi_reg_iy_in  <= '0;
            z80fi_reg_ip_out <= '0;
            z80fi_reg_f_out  <= '0;
            z80fi_overflow   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                out_type[i] <= CYCLE_NONE;
                acc_type[i] <= CYCLE_NONE;
            end
            for (int i = 0; i < 5; i++) begin
                out_tcyc[i] <= '0;
                acc_tcyc[i] <= '0;
            end
            acc_insn  <= '0;
            acc_len   <= '0;
            mc_idx    <= '0;
            tcnt      <= '0;
            acc_raddr <= '0;
            acc_rdata <= '0;
            rd_seen   <= 1'b0;
            acc_ovf   <= 1'b0;
            sh_ip     <= '0;
            sh_f      <= '0;
            sh_ix     <= '0;
            sh_iy     <= '0;
        end else begin
            z80fi_valid <= retire;
            if (retire) begin
                z80fi_insn       <= acc_insn;
                z80fi_insn_len   <= acc_len;
                z80fi_bus_raddr  <= acc_raddr;
                z80fi_bus_rdata  <= acc_rdata;
                z80fi_reg_ip_in  <= sh_ip;
                z80fi_reg_f_in   <= sh_f;
                z80fi_reg_ix_in  <= sh_ix;
                z80fi_reg_iy_in  <= sh_iy;
                z80fi_reg_ip_out <= cpu_ip;
                z80fi_reg_f_out  <= cpu_f;
                z80fi_overflow   <= acc_ovf;
                for (int i = 0; i < 6; i++) out_type[i] <= acc_type[i];
                for (int i = 0; i < 5; i++) out_tcyc[i] <= fin_tcyc[i];
            end

            // Anything seen on the insn_start clk belongs to the instruction being opened
            if (open_new) begin
                sh_ip     <= cpu_ip;
                sh_f      <= cpu_f;
                sh_ix     <= cpu_ix;
                sh_iy     <= cpu_iy;
                acc_insn  <= fetch_valid ? {24'd0, fetch_byte} : 32'd0;
                acc_len   <= {2'b00, fetch_valid};
                acc_type[0] <= mcycle_type;
                for (int i = 1; i < 6; i++) acc_type[i] <= CYCLE_NONE;
                for (int i = 0; i < 5; i++) acc_tcyc[i] <= '0;
                mc_idx    <= 3'd1;
                tcnt      <= TCYC_ONE;
                rd_seen   <= mem_rd_valid;
                acc_raddr <= mem_rd_valid ? mem_raddr : 16'd0;
                acc_rdata <= mem_rd_valid ? mem_rdata : 8'd0;
                acc_ovf   <= 1'b0;
            end else if (track) begin
                if (fetch_valid) begin
                    if (acc_len[2]) begin
                        acc_ovf <= 1'b1;
                    end else begin
                        acc_insn[{acc_len[1:0], 3'b000} +: 8] <= fetch_byte;
                        acc_len <= acc_len + 3'd1;
                    end
                end
                if (mem_rd_valid && !rd_seen) begin
                    rd_seen   <= 1'b1;
                    acc_raddr <= mem_raddr;
                    acc_rdata <= mem_rdata;
                end
                if (mcycle_start) begin
                    for (int i = 0; i < 5; i++) acc_tcyc[i] <= fin_tcyc[i];
                    for (int i = 1; i < 6; i++)
                        if (mc_idx == 3'(i)) acc_type[i] <= mcycle_type;
                    if (mc_idx >= 3'd6) acc_ovf <= 1'b1;
                    if (mc_idx != 3'd7) mc_idx <= mc_idx + 3'd1;
                    tcnt <= TCYC_ONE;
                end else if (tcnt != TCYC_MAX) begin
                    tcnt <= tcnt + TCYC_ONE;
                end
            end
        end
    end

    assign z80fi_mcycle_type1 = out_type[0];
    assign z80fi_mcycle_type2 = out_type[1];
    assign z80fi_mcycle_type3 = out_type[2];
    assign z80fi_mcycle_type4 = out_type[3];
    assign z80fi_mcycle_type5 = out_type[4];
    assign z80fi_mcycle_type6 = out_type[5];
    assign z80fi_tcycles1     = out_tcyc[0];
    assign z80fi_tcycles2     = out_tcyc[1];
    assign z80fi_tcycles3     = out_tcyc[2];
    assign z80fi_tcycles4     = out_tcyc[3];
    assign z80fi_tcycles5     = out_tcyc[4];

endmodule

// File: tb/tb_z80fi_insn_capture.sv
// Bench for z80fi_insn_capture: instructions described abstractly, expected record computed from the description.
module tb_z80fi_insn_capture;
    localparam int TCYC_W = 4;
    localparam int TMAX   = 15;
    localparam logic [2:0] CYC_NONE = 3'd0;
    localparam logic [2:0] CYC_M1   = 3'd1;
    localparam logic [2:0] CYC_MEM  = 3'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, insn_start, mcycle_start, fetch_valid, mem_rd_valid;
    logic [2:0]  mcycle_type;
    logic [7:0]  fetch_byte, mem_rdata, cpu_f;
    logic [15:0] mem_raddr, cpu_ip, cpu_ix, cpu_iy;
    logic        z80fi_valid, z80fi_overflow;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_bus_raddr, z80fi_reg_ip_in, z80fi_reg_ix_in, z80fi_reg_iy_in, z80fi_reg_ip_out;
    logic [7:0]  z80fi_bus_rdata, z80fi_reg_f_in, z80fi_reg_f_out;
    logic [2:0]  o_ty [6];
    logic [TCYC_W-1:0] o_tc [5];

    z80fi_insn_capture #(.TCYC_W(TCYC_W)) dut (
        .clk(clk), .reset(reset), .insn_start(insn_start), .mcycle_start(mcycle_start),
        .mcycle_type(mcycle_type), .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
        .mem_rd_valid(mem_rd_valid), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .cpu_ip(cpu_ip), .cpu_f(cpu_f), .cpu_ix(cpu_ix), .cpu_iy(cpu_iy),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_bus_raddr(z80fi_bus_raddr), .z80fi_bus_rdata(z80fi_bus_rdata),
        .z80fi_reg_ip_in(z80fi_reg_ip_in), .z80fi_reg_f_in(z80fi_reg_f_in),
        .z80fi_reg_ix_in(z80fi_reg_ix_in), .z80fi_reg_iy_in(z80fi_reg_iy_in),
        .z80fi_reg_ip_out(z80fi_reg_ip_out), .z80fi_reg_f_out(z80fi_reg_f_out),
        .z80fi_mcycle_type1(o_ty[0]), .z80fi_mcycle_type2(o_ty[1]), .z80fi_mcycle_type3(o_ty[2]),
        .z80fi_mcycle_type4(o_ty[3]), .z80fi_mcycle_type5(o_ty[4]), .z80fi_mcycle_type6(o_ty[5]),
        .z80fi_tcycles1(o_tc[0]), .z80fi_tcycles2(o_tc[1]), .z80fi_tcycles3(o_tc[2]),
        .z80fi_tcycles4(o_tc[3]), .z80fi_tcycles5(o_tc[4]),
        .z80fi_overflow(z80fi_overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // instruction description
    int          d_nb, d_nmc, d_nrd;
    logic [7:0]  d_bytes [8];
    logic [2:0]  d_ty [8];
    int          d_ln [8];
    int          d_rpos [2];
    logic [15:0] d_ra [2];
    logic [7:0]  d_rd [2];
    logic [15:0] d_ip, d_ix, d_iy;
    logic [7:0]  d_f;

    // expected record of the open (not yet retired) instruction
    bit          p_valid;
    logic [31:0] p_insn;
    logic [2:0]  p_len;
    logic        p_ovf;
    logic [2:0]  p_ty [6];
    logic [3:0]  p_tc [5];
    logic [15:0] p_ra, p_ip, p_ix, p_iy;
    logic [7:0]  p_rd, p_f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model();
        int n4;
        n4 = (d_nb < 4) ? d_nb : 4;
        p_insn = 32'd0;
        for (int k = 0; k < n4; k++) p_insn[8*k +: 8] = d_bytes[k];
        p_len = 3'(n4);
        p_ovf = (d_nb > 4) || (d_nmc > 6);
        for (int i = 0; i < 6; i++) p_ty[i] = (i < d_nmc) ? d_ty[i] : CYC_NONE;
        for (int i = 0; i < 5; i++) p_tc[i] = (i < d_nmc) ? 4'((d_ln[i] > TMAX) ? TMAX : d_ln[i]) : 4'd0;
        p_ra = (d_nrd > 0) ? d_ra[0] : 16'd0;
        p_rd = (d_nrd > 0) ? d_rd[0] : 8'd0;
        p_ip = d_ip; p_f = d_f; p_ix = d_ix; p_iy = d_iy;
        p_valid = 1'b1;
    endtask

    task automatic check_record(input logic [15:0] ip_out, input logic [7:0] f_out);
        chk("insn", z80fi_insn, p_insn);
        chk("len", 32'(z80fi_insn_len), 32'(p_len));
        chk("overflow", 32'(z80fi_overflow), 32'(p_ovf));
        chk("raddr", 32'(z80fi_bus_raddr), 32'(p_ra));
        chk("rdata", 32'(z80fi_bus_rdata), 32'(p_rd));
        chk("ip_in", 32'(z80fi_reg_ip_in), 32'(p_ip));
        chk("f_in", 32'(z80fi_reg_f_in), 32'(p_f));
        chk("ix_in", 32'(z80fi_reg_ix_in), 32'(p_ix));
        chk("iy_in", 32'(z80fi_reg_iy_in), 32'(p_iy));
        chk("ip_out", 32'(z80fi_reg_ip_out), 32'(ip_out));
        chk("f_out", 32'(z80fi_reg_f_out), 32'(f_out));
        for (int i = 0; i < 6; i++) chk($sformatf("type%0d", i + 1), 32'(o_ty[i]), 32'(p_ty[i]));
        for (int i = 0; i < 5; i++) chk($sformatf("tcycles%0d", i + 1), 32'(o_tc[i]), 32'(p_tc[i]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(z80fi_valid), 0);
        chk({tag, "_insn"}, z80fi_insn, 0);
        chk({tag, "_len"}, 32'(z80fi_insn_len), 0);
        chk({tag, "_ovf"}, 32'(z80fi_overflow), 0);
        chk({tag, "_raddr"}, 32'(z80fi_bus_raddr), 0);
        chk({tag, "_rdata"}, 32'(z80fi_bus_rdata), 0);
        chk({tag, "_regs"}, {z80fi_reg_ip_in, z80fi_reg_ip_out}, 0);
        chk({tag, "_regs2"}, {z80fi_reg_ix_in, z80fi_reg_iy_in}, 0);
        chk({tag, "_flags"}, {16'd0, z80fi_reg_f_in, z80fi_reg_f_out}, 0);
        for (int i = 0; i < 6; i++) chk({tag, "_type"}, 32'(o_ty[i]), 32'(CYC_NONE));
        for (int i = 0; i < 5; i++) chk({tag, "_tcyc"}, 32'(o_tc[i]), 0);
    endtask

    task automatic idle_inputs();
        insn_start = 0; mcycle_start = 0; fetch_valid = 0; mem_rd_valid = 0;
        mcycle_type = 3'($urandom); fetch_byte = 8'($urandom);
        mem_raddr = 16'($urandom); mem_rdata = 8'($urandom);
        cpu_ip = 16'($urandom); cpu_f = 8'($urandom); cpu_ix = 16'($urandom); cpu_iy = 16'($urandom);
    endtask

    task automatic apply_reset(input bit with_start);
        idle_inputs();
        reset = 1; insn_start = with_start; mcycle_start = with_start;
        fetch_valid = with_start; mem_rd_valid = with_start;
        @(posedge clk); #1;
        chk_zero("reset");
        idle_inputs();
        @(posedge clk); #1;
        chk("reset_valid", 32'(z80fi_valid), 0);
        reset = 0;
        p_valid = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        for (int t = 0; t < n; t++) begin
            idle_inputs();
            mcycle_start = 1'($urandom); fetch_valid = 1'($urandom); mem_rd_valid = 1'($urandom);
            @(posedge clk); #1;
            chk("idle_valid", 32'(z80fi_valid), 0);
        end
    endtask

    // Drives one described instruction; abort_at >= 0 resets at that clk instead.
    task automatic run_insn(input int abort_at);
        int st [8];
        int acc, m;
        acc = 0;
        for (int i = 0; i < d_nmc; i++) begin st[i] = acc; acc += d_ln[i]; end
        for (int t = 0; t < acc; t++) begin
            if (t == abort_at) begin
                apply_reset(1'b0);
                return;
            end
            idle_inputs();
            m = -1;
            for (int i = 0; i < d_nmc; i++) if (st[i] == t) m = i;
            insn_start = (t == 0);
            mcycle_start = (m >= 0);
            if (m >= 0) mcycle_type = d_ty[m];
            fetch_valid = (t < d_nb);
            if (t < d_nb) fetch_byte = d_bytes[t];
            for (int r = 0; r < d_nrd; r++)
                if (d_rpos[r] == t) begin
                    mem_rd_valid = 1; mem_raddr = d_ra[r]; mem_rdata = d_rd[r];
                end
            if (t == 0) begin cpu_ip = d_ip; cpu_f = d_f; cpu_ix = d_ix; cpu_iy = d_iy; end
            @(posedge clk); #1;
            if (t == 0 && p_valid) begin
                chk("retire_valid", 32'(z80fi_valid), 1);
                check_record(d_ip, d_f);
            end else begin
                chk("valid_low", 32'(z80fi_valid), 0);
            end
        end
        model();
    endtask

    task automatic set_common(input logic [15:0] ip);
        d_ip = ip; d_f = 8'($urandom); d_ix = 16'($urandom); d_iy = 16'($urandom);
        d_nrd = 0;
        for (int k = 0; k < 8; k++) d_bytes[k] = 8'($urandom);
    endtask

    task automatic set_nop(input logic [15:0] ip);
        set_common(ip);
        d_nmc = 1; d_ty[0] = CYC_M1; d_ln[0] = 4; d_nb = 1; d_bytes[0] = 8'h00;
    endtask

    task automatic gen_random();
        int tt;
        set_common(16'($urandom));
        d_nmc = $urandom_range(1, 8);
        tt = 0;
        for (int i = 0; i < d_nmc; i++) begin
            d_ty[i] = 3'($urandom_range(1, 7));
            d_ln[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(1, 6);
            tt += d_ln[i];
        end
        d_nb  = $urandom_range(0, (tt < 6) ? tt : 6);
        d_nrd = $urandom_range(0, (tt < 2) ? tt : 2);
        for (int r = 0; r < 2; r++) begin d_ra[r] = 16'($urandom); d_rd[r] = 8'($urandom); end
        if (d_nrd == 1) d_rpos[0] = $urandom_range(0, tt - 1);
        if (d_nrd == 2) begin
            d_rpos[0] = $urandom_range(0, tt - 2);
            d_rpos[1] = $urandom_range(d_rpos[0] + 1, tt - 1);
        end
    endtask

    initial begin
        reset = 1; p_valid = 1'b0;
        idle_inputs();
        apply_reset(1'b1);
        idle_noise(5);

        // two NOPs
        set_nop(16'h0100); run_insn(-1);
        set_nop(16'h0101); run_insn(-1);
        set_nop(16'h0102); run_insn(-1);
        chk("nop_insn", z80fi_insn, 32'h0);
        chk("nop_len", 32'(z80fi_insn_len), 1);
        chk("nop_tc1", 32'(o_tc[0]), 4);
        chk("nop_ty2", 32'(o_ty[1]), 32'(CYC_NONE));
        chk("nop_ipout", 32'(z80fi_reg_ip_out), 32'h0102);

        // DD CB 05 7E : bit 7,(ix+5)
        set_common(16'h2000);
        d_ix = 16'h1000; d_nb = 4;
        d_bytes[0] = 8'hDD; d_bytes[1] = 8'hCB; d_bytes[2] = 8'h05; d_bytes[3] = 8'h7E;
        d_nmc = 5;
        d_ty[0] = CYC_M1; d_ty[1] = CYC_M1; d_ty[2] = CYC_MEM; d_ty[3] = CYC_MEM; d_ty[4] = CYC_MEM;
        d_ln[0] = 4; d_ln[1] = 4; d_ln[2] = 3; d_ln[3] = 5; d_ln[4] = 4;
        d_nrd = 1; d_rpos[0] = 14; d_ra[0] = 16'h1005; d_rd[0] = 8'h80;
        run_insn(-1);
        set_nop(16'h2004); run_insn(-1);
        chk("ix_insn", z80fi_insn, 32'h7E05CBDD);
        chk("ix_len", 32'(z80fi_insn_len), 4);
        chk("ix_raddr", 32'(z80fi_bus_raddr), 32'h1005);
        chk("ix_rdata", 32'(z80fi_bus_rdata), 32'h80);
        chk("ix_tc", {12'd0, o_tc[0], o_tc[1], o_tc[2], o_tc[3], o_tc[4]}, 32'h44354);
        chk("ix_ipout", 32'(z80fi_reg_ip_out), 32'h2004);

        // five fetch bytes
        set_common(16'h3000);
        d_nmc = 2; d_ty[0] = CYC_M1; d_ty[1] = CYC_M1; d_ln[0] = 4; d_ln[1] = 4; d_nb = 5;
        run_insn(-1);
        set_nop(16'h3005); run_insn(-1);
        chk("ovf5_flag", 32'(z80fi_overflow), 1);
        chk("ovf5_len", 32'(z80fi_insn_len), 4);

        // seven M-cycles
        set_common(16'h4000);
        d_nmc = 7; d_nb = 2;
        for (int i = 0; i < 7; i++) begin d_ty[i] = 3'(i + 1); d_ln[i] = 3; end
        run_insn(-1);
        set_nop(16'h4002); run_insn(-1);
        chk("ovf7_flag", 32'(z80fi_overflow), 1);

        // 20 T-state M-cycle saturates
        set_common(16'h5000);
        d_nmc = 1; d_ty[0] = CYC_M1; d_ln[0] = 20; d_nb = 1;
        run_insn(-1);
        set_nop(16'h5001); run_insn(-1);
        chk("sat_tc1", 32'(o_tc[0]), 15);

        // back-to-back single-clk instructions with a byte on each insn_start
        for (int i = 0; i < 6; i++) begin
            set_common(16'(16'h6000 + i));
            d_nmc = 1; d_ty[0] = CYC_M1; d_ln[0] = 1; d_nb = 1;
            run_insn(-1);
        end

        // reset mid-instruction, then two instructions
        set_nop(16'h7000); d_ln[0] = 6; run_insn(3);
        set_nop(16'h7100); run_insn(-1);
        set_nop(16'h7101); run_insn(-1);

        for (int n = 0; n < 300; n++) begin
            gen_random();
            run_insn(-1);
        end
        set_nop(16'h8000); run_insn(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
